result_writeback: RTL and testbench

//   Write-back end of the NPU datapath: captures the NxN accumulator tile from the systolic array
//   (results_flat/result_valid), requantizes each ACC_WIDTH value to DATA_WIDTH, packs one array
//   row per buffer word and writes N words into the unified buffer write port (wr_en/addr/data).

---
 rtl/result_writeback_pkg.sv | 70 +++++++
 rtl/result_writeback_if.sv | 17 +
 rtl/result_writeback_requant_lane.sv | 18 +
 rtl/result_writeback.sv | 192 +++++++++++++++++++
 tb/tb_result_writeback.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/result_writeback_pkg.sv
// Shared definitions for the result write-back path.
// Holds the write-back FSM state type, the element widths the requant helper is
// built for, and the requant function itself so other output paths can reuse it.
package result_writeback_pkg;

    localparam int WB_DATA_WIDTH  = 8;
    localparam int WB_ACC_WIDTH   = 32;
    localparam int WB_SHIFT_WIDTH = 6;

    // Constants in the ACC_WIDTH+1 working width used by requant.
    localparam logic signed [WB_ACC_WIDTH:0] WB_ONE =
        {{WB_ACC_WIDTH{1'b0}}, 1'b1};
    localparam logic signed [WB_ACC_WIDTH:0] WB_SAT_MAX =
        {{(WB_ACC_WIDTH - WB_DATA_WIDTH + 2){1'b0}}, {(WB_DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [WB_ACC_WIDTH:0] WB_SAT_MIN =
        {{(WB_ACC_WIDTH - WB_DATA_WIDTH + 2){1'b1}}, {(WB_DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        WB_IDLE       = 2'd0,
        WB_WAIT_VALID = 2'd1,
        WB_WRITE      = 2'd2,
        WB_DONE       = 2'd3
    } wb_state_t;

    // Requantize one accumulator value: round-half-up arithmetic shift, optional
    // ReLU, then saturation. Returns {sat, data}; sat reports only the saturation
    // clamp, never the ReLU clamp. One extra bit of headroom keeps the rounding
    // add from overflowing.
    function automatic logic [WB_DATA_WIDTH:0] requant(
        input logic signed [WB_ACC_WIDTH-1:0]   acc,
        input logic        [WB_SHIFT_WIDTH-1:0] shift,
        input logic                             relu_en
    );
        logic signed [WB_ACC_WIDTH:0] ext_v;
        logic signed [WB_ACC_WIDTH:0] y_v;
        logic                         sat_v;
        logic [WB_DATA_WIDTH-1:0]     data_v;

        ext_v = {acc[WB_ACC_WIDTH-1], acc};
        if (shift == {WB_SHIFT_WIDTH{1'b0}}) begin
            y_v = ext_v;
        end else if (int'(shift) >= WB_ACC_WIDTH) begin
            // Every magnitude bit is shifted out: only the sign survives.
            y_v = acc[WB_ACC_WIDTH-1] ? {(WB_ACC_WIDTH + 1){1'b1}}
                                      : {(WB_ACC_WIDTH + 1){1'b0}};
        end else begin
            y_v = (ext_v + (WB_ONE <<< (shift - {{(WB_SHIFT_WIDTH - 1){1'b0}}, 1'b1})))
                  >>> shift;
        end

        if (relu_en && y_v[WB_ACC_WIDTH]) begin
            y_v = {(WB_ACC_WIDTH + 1){1'b0}};
        end else begin
            y_v = y_v;
        end

        if (y_v > WB_SAT_MAX) begin
            data_v = WB_SAT_MAX[WB_DATA_WIDTH-1:0];
            sat_v  = 1'b1;
        end else if (y_v < WB_SAT_MIN) begin
            data_v = WB_SAT_MIN[WB_DATA_WIDTH-1:0];
            sat_v  = 1'b1;
        end else begin
            data_v = y_v[WB_DATA_WIDTH-1:0];
            sat_v  = 1'b0;
        end
        return {sat_v, data_v};
    endfunction

endpackage

// File: rtl/result_writeback_if.sv
// Unified buffer write port as seen from a writer.
//   wr_en   : write request (writer -> buffer)
//   wr_addr : word address  (writer -> buffer)
//   wr_data : word data     (writer -> buffer)
//   wr_gnt  : write accepted this cycle (buffer -> writer)
interface result_writeback_if #(
    parameter int ADDR_WIDTH   = 8,
    parameter int BUFFER_WIDTH = 32
) ();
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [BUFFER_WIDTH-1:0] wr_data;
    logic                    wr_gnt;

    modport master (output wr_en, output wr_addr, output wr_data, input wr_gnt);
    modport slave  (input wr_en, input wr_addr, input wr_data, output wr_gnt);
endinterface

// File: rtl/result_writeback_requant_lane.sv
// One combinational requant lane: a single accumulator element in, one stored
// element plus its saturation indication out.
//   acc     : signed accumulator value
//   shift   : arithmetic right shift amount
//   relu_en : clamp negative results to zero
//   data    : requantized element
//   sat     : element was clamped by saturation
module requant_lane
    import result_writeback_pkg::*;
(
    input  logic [WB_ACC_WIDTH-1:0]   acc,
    input  logic [WB_SHIFT_WIDTH-1:0] shift,
    input  logic                      relu_en,
    output logic [WB_DATA_WIDTH-1:0]  data,
    output logic                      sat
);
    assign {sat, data} = requant($signed(acc), shift, relu_en);
endmodule

// File: rtl/result_writeback.sv
// Write-back end of the NPU datapath. Captures an NxN accumulator tile, requantizes
// each element and writes one packed row per unified-buffer word.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : begin a tile (sampled in IDLE with base_addr/shift/relu_en)
//   results_flat    : NxN tile, element (r,c) at [(r*N+c+1)*ACC_WIDTH-1 -: ACC_WIDTH]
//   result_valid    : tile complete this cycle (used only while waiting for it)
//   ub              : buffer write port (wr_en/wr_addr/wr_data out, wr_gnt in)
//   busy            : waiting for the tile or writing rows
//   done            : one-cycle pulse after the last row is accepted
//   sat_flag        : sticky per tile, some element saturated
module result_writeback
    import result_writeback_pkg::*;
#(
    parameter int N            = 4,
    parameter int DATA_WIDTH   = WB_DATA_WIDTH,
    parameter int ACC_WIDTH    = WB_ACC_WIDTH,
    parameter int ADDR_WIDTH   = 8,
    parameter int BUFFER_WIDTH = N * DATA_WIDTH,
    parameter int SHIFT_WIDTH  = WB_SHIFT_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic [SHIFT_WIDTH-1:0]     shift,
    input  logic                       relu_en,
    input  logic [N*N*ACC_WIDTH-1:0]   results_flat,
    input  logic                       result_valid,
    result_writeback_if.master         ub,
    output logic                       busy,
    output logic                       done,
    output logic                       sat_flag
);
    localparam int ROW_W = (N > 1) ? $clog2(N) : 1;

    if (BUFFER_WIDTH != N * DATA_WIDTH) begin : g_bad_buffer_width
        $error("BUFFER_WIDTH must equal N*DATA_WIDTH");
    end
    if (DATA_WIDTH != WB_DATA_WIDTH || ACC_WIDTH != WB_ACC_WIDTH ||
        SHIFT_WIDTH != WB_SHIFT_WIDTH) begin : g_bad_elem_width
        $error("element widths must match the requant helper widths");
    end

    wb_state_t               state_r, state_nx;
    logic [ROW_W-1:0]        row_r;
    logic [ROW_W-1:0]        next_row_s;
    logic                    last_row_s;
    logic [N*N*ACC_WIDTH-1:0] snap_r;
    logic [ADDR_WIDTH-1:0]   base_r;
    logic [SHIFT_WIDTH-1:0]  shift_r;
    logic                    relu_r;
    logic                    wr_en_r;
    logic [ADDR_WIDTH-1:0]   wr_addr_r;
    logic [BUFFER_WIDTH-1:0] wr_data_r;
    logic                    busy_r, done_r, sat_r;
    logic                    load_s, capture_s, accept_s;

    logic [ACC_WIDTH-1:0]    lane_acc_s  [N];
    logic [DATA_WIDTH-1:0]   lane_data_s [N];
    logic [N-1:0]            lane_sat_s;
    logic [BUFFER_WIDTH-1:0] wr_data_s;

    assign next_row_s = row_r + {{(ROW_W - 1){1'b0}}, 1'b1};
    assign last_row_s = (row_r == ROW_W'(N - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= WB_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state decode and one-cycle control strobes.
    always_comb begin
        state_nx  = state_r;
        load_s    = 1'b0;
        capture_s = 1'b0;
        accept_s  = 1'b0;
        case (state_r)
            WB_IDLE: begin
                if (start) begin
                    load_s   = 1'b1;
                    state_nx = WB_WAIT_VALID;
                end else begin
                    state_nx = WB_IDLE;
                end
            end
            WB_WAIT_VALID: begin
                if (result_valid) begin
                    capture_s = 1'b1;
                    state_nx  = WB_WRITE;
                end else begin
                    state_nx = WB_WAIT_VALID;
                end
            end
            WB_WRITE: begin
                if (wr_en_r && ub.wr_gnt) begin
                    accept_s = 1'b1;
                    state_nx = last_row_s ? WB_DONE : WB_WRITE;
                end else begin
                    state_nx = WB_WRITE;
                end
            end
            WB_DONE: begin
                state_nx = WB_IDLE;
            end
            default: begin
                state_nx = WB_IDLE;
            end
        endcase
    end

    // Lane input select: row 0 comes straight off the array on the capture cycle
    // (the snapshot is not loaded yet); later rows come from the snapshot.
    always_comb begin
        for (int c = 0; c < N; c++) begin
            if (state_r == WB_WAIT_VALID) begin
                lane_acc_s[c] = results_flat[(c + 1) * ACC_WIDTH - 1 -: ACC_WIDTH];
            end else begin
                lane_acc_s[c] =
                    snap_r[(int'(next_row_s) * N + c + 1) * ACC_WIDTH - 1 -: ACC_WIDTH];
            end
        end
    end

    for (genvar c = 0; c < N; c++) begin : g_lane
        requant_lane u_lane (
            .acc     (lane_acc_s[c]),
            .shift   (shift_r),
            .relu_en (relu_r),
            .data    (lane_data_s[c]),
            .sat     (lane_sat_s[c])
        );
    end

    // Pack lane outputs into one buffer word, column c in slice c.
    always_comb begin
        wr_data_s = {BUFFER_WIDTH{1'b0}};
        for (int c = 0; c < N; c++) begin
            wr_data_s[c * DATA_WIDTH +: DATA_WIDTH] = lane_data_s[c];
        end
    end

    // Parameter latch, tile snapshot, row counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_r     <= {ROW_W{1'b0}};
            snap_r    <= {(N * N * ACC_WIDTH){1'b0}};
            base_r    <= {ADDR_WIDTH{1'b0}};
            shift_r   <= {SHIFT_WIDTH{1'b0}};
            relu_r    <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= {ADDR_WIDTH{1'b0}};
            wr_data_r <= {BUFFER_WIDTH{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            sat_r     <= 1'b0;
        end else begin
            wr_en_r <= (state_nx == WB_WRITE);
            busy_r  <= (state_nx == WB_WAIT_VALID) || (state_nx == WB_WRITE);
            done_r  <= (state_nx == WB_DONE);
            if (load_s) begin
                base_r  <= base_addr;
                shift_r <= shift;
                relu_r  <= relu_en;
                sat_r   <= 1'b0;
            end else if (capture_s) begin
                snap_r    <= results_flat;
                row_r     <= {ROW_W{1'b0}};
                wr_addr_r <= base_r;
                wr_data_r <= wr_data_s;
                sat_r     <= sat_r | (|lane_sat_s);
            end else if (accept_s && !last_row_s) begin
                // Address arithmetic wraps naturally at the address width.
                row_r     <= next_row_s;
                wr_addr_r <= base_r + ADDR_WIDTH'(next_row_s);
                wr_data_r <= wr_data_s;
                sat_r     <= sat_r | (|lane_sat_s);
            end
        end
    end

    assign ub.wr_en   = wr_en_r;
    assign ub.wr_addr = wr_addr_r;
    assign ub.wr_data = wr_data_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign sat_flag   = sat_r;

endmodule

// File: tb/tb_result_writeback.sv
// Randomized self-checking bench for result_writeback (N=4, 8-bit data, 32-bit acc).
module tb_result_writeback;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    base_addr = 8'd0;
    logic [5:0]    shift = 6'd0;
    logic          relu_en = 1'b0;
    logic [511:0]  results_flat = '0;
    logic          result_valid = 1'b0;
    logic          busy, done, sat_flag;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int tile_q[16];

    result_writeback_if #(.ADDR_WIDTH(8), .BUFFER_WIDTH(32)) ub ();

    result_writeback #(
        .N(4), .DATA_WIDTH(8), .ACC_WIDTH(32), .ADDR_WIDTH(8), .BUFFER_WIDTH(32), .SHIFT_WIDTH(6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .shift        (shift),
        .relu_en      (relu_en),
        .results_flat (results_flat),
        .result_valid (result_valid),
        .ub           (ub),
        .busy         (busy),
        .done         (done),
        .sat_flag     (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference requant from the arithmetic rules: floor((x + 2^(s-1)) / 2^s).
    function automatic void ref_requant(input int x, input int sh, input bit relu,
                                        output int y, output bit sat);
        longint v, d, num, q;
        if (sh == 0) begin
            v = x;
        end else if (sh >= 32) begin
            v = (x < 0) ? -1 : 0;
        end else begin
            d   = longint'(1) << sh;
            num = longint'(x) + d / 2;
            q   = num / d;
            if ((num % d) != 0 && num < 0) q = q - 1;
            v = q;
        end
        if (relu && v < 0) v = 0;
        sat = 1'b0;
        if (v > 127) begin
            v = 127; sat = 1'b1;
        end else if (v < -128) begin
            v = -128; sat = 1'b1;
        end
        y = int'(v);
    endfunction

    function automatic int rand_acc();
        case ($urandom_range(0, 3))
            0: return int'($urandom_range(0, 400)) - 200;
            1: return int'($urandom_range(0, 200000)) - 100000;
            2: return int'($urandom_range(0, 2000)) - 1000;
            default: return int'($urandom);
        endcase
    endfunction

    // gmode: 0 = grant always, 1 = pattern 1,0,0,1,0,1,1 then 1, 2 = random grant.
    task automatic run_tile(input logic [7:0] base, input int sh, input bit relu, input int gmode,
                            input bit scramble, input bit pulse_start, input int abort_after);
        logic [31:0] exp_w[N];
        bit          exp_sat;
        int          y, acc_cnt, idx, last_acc_idx;
        bit          s, gnt, hold, seen_done, aborted;
        logic [7:0]  prev_addr;
        logic [31:0] prev_data;
        bit          pat[7];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_sat = 1'b0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                ref_requant(tile_q[r*N+c], sh, relu, y, s);
                exp_w[r][c*8 +: 8] = y[7:0];
                exp_sat = exp_sat | s;
            end
        end
        @(negedge clk);
        start = 1'b1; base_addr = base; shift = 6'(sh); relu_en = relu;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_wait_valid", busy, 1);
        check_eq("no_write_wait_valid", ub.wr_en, 0);
        for (int i = 0; i < 16; i++) results_flat[i*32 +: 32] = tile_q[i];
        result_valid = 1'b1;
        @(negedge clk);
        result_valid = 1'b0;
        if (scramble) begin
            for (int i = 0; i < 16; i++) results_flat[i*32 +: 32] = $urandom;
        end
        acc_cnt = 0; idx = 1; last_acc_idx = -1; hold = 1'b0;
        seen_done = 1'b0; aborted = 1'b0; prev_addr = '0; prev_data = '0;
        while (!seen_done && idx < 60) begin
            if (gmode == 1)      gnt = (idx - 1 < 7) ? pat[idx-1] : 1'b1;
            else if (gmode == 2) gnt = ($urandom_range(0, 2) != 0);
            else                 gnt = 1'b1;
            ub.wr_gnt = gnt;
            start = pulse_start && (idx <= 3) && (idx % 2 == 1);
            if (start) begin
                base_addr = ~base; shift = 6'd5; relu_en = ~relu;
            end
            if (done) begin
                seen_done = 1'b1;
                check_eq("rows_written", acc_cnt, N);
                check_eq("done_after_last_accept", idx, last_acc_idx + 1);
                if (gmode == 0) check_eq("done_latency", idx, N + 1);
                check_eq("sat_flag", sat_flag, exp_sat);
                check_eq("wr_en_in_done", ub.wr_en, 0);
            end else if (ub.wr_en) begin
                if (hold) begin
                    check_eq("hold_addr", ub.wr_addr, prev_addr);
                    check_eq("hold_data", ub.wr_data, prev_data);
                end
                if (gnt) begin
                    check_eq("wr_addr", ub.wr_addr, 8'(base + 8'(acc_cnt)));
                    check_eq("wr_data", ub.wr_data, exp_w[acc_cnt]);
                    acc_cnt++;
                    last_acc_idx = idx;
                end
                hold = !gnt; prev_addr = ub.wr_addr; prev_data = ub.wr_data;
            end else begin
                check_eq("wr_en_while_writing", ub.wr_en, 1);
            end
            @(negedge clk);
            idx++;
            if (abort_after > 0 && acc_cnt == abort_after) begin
                aborted = 1'b1;
                break;
            end
        end
        start = 1'b0;
        ub.wr_gnt = 1'b1;
        if (aborted) begin
            rst_n = 1'b0;
            #1;
            check_eq("rst_wr_en", ub.wr_en, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_done", done, 0);
            check_eq("rst_sat_flag", sat_flag, 0);
            @(negedge clk);
            rst_n = 1'b1;
            result_valid = 1'b1;
            repeat (2) begin
                @(negedge clk);
                check_eq("idle_ignores_valid_wr_en", ub.wr_en, 0);
                check_eq("idle_ignores_valid_busy", busy, 0);
            end
            result_valid = 1'b0;
        end else begin
            check_eq("done_seen", seen_done, 1);
            check_eq("done_pulse_low", done, 0);
            check_eq("busy_after_done", busy, 0);
        end
    endtask

    initial begin
        ub.wr_gnt = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset_wr_en", ub.wr_en, 0);
        check_eq("reset_wr_addr", ub.wr_addr, 0);
        check_eq("reset_wr_data", ub.wr_data, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_sat_flag", sat_flag, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic tile: element (r,c) = r*4+c.
        for (int i = 0; i < 16; i++) tile_q[i] = i;
        run_tile(8'h10, 0, 1'b0, 0, 1'b0, 1'b0, 0);

        // Requant corner values with shift 2.
        tile_q = '{6, -6, 1000, -1000, 1, 2, -2, -3, 5, 7, -7, 510, -510, 514, 0, -1};
        run_tile(8'h20, 2, 1'b0, 0, 1'b0, 1'b0, 0);

        // ReLU clamps negatives without touching sat_flag.
        tile_q = '{-6, 6, -1000, 12, -1, 3, -2000000, 100, 0, -5, 8, -9, 44, -44, 400, -400};
        run_tile(8'h30, 2, 1'b1, 0, 1'b0, 1'b0, 0);

        // Backpressure pattern with start pulses while busy.
        for (int i = 0; i < 16; i++) tile_q[i] = rand_acc();
        run_tile(8'h40, 3, 1'b0, 1, 1'b0, 1'b1, 0);

        // Address wrap and tile isolation.
        for (int i = 0; i < 16; i++) tile_q[i] = rand_acc();
        run_tile(8'hFE, 1, 1'b0, 0, 1'b1, 1'b0, 0);

        // Reset after row 1 accepted, then a full fresh tile.
        for (int i = 0; i < 16; i++) tile_q[i] = 1000 + i;
        run_tile(8'h50, 0, 1'b0, 0, 1'b0, 1'b0, 2);
        for (int i = 0; i < 16; i++) tile_q[i] = rand_acc();
        run_tile(8'h60, 4, 1'b0, 0, 1'b0, 1'b0, 0);

        // Random tiles, shifts, ReLU and grant patterns.
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 16; i++) tile_q[i] = rand_acc();
            run_tile(8'($urandom), int'($urandom_range(0, 40)), 1'($urandom), 2,
                     1'($urandom), 1'($urandom), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
